axi_burst_master: RTL and testbench

//  AXI4 master: turns one simple command (read/write, address, beat count) into a single INCR burst.

---
 rtl/axi_burst_master.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master with stream data ports
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  // write beat stream
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read beat stream
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
  // AXI4 AW
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI4 W
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI4 B
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4 AR
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4 R
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  started_q, started_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]            resp_q, resp_d;

  logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
  logic [31:0]           burst_end;
  logic                  crosses_4k;
  logic                  last_beat;

  // IDs are constant per transaction, so returned bid/rid carry no information
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Constant AXI attributes and straight-through data paths
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awsize  = 3'(ADDR_LSB);
  assign m_axi_arsize  = 3'(ADDR_LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;
  assign done_write    = write_q;

  // Alignment and 4 KB crossing test on the incoming command
  always_comb begin
    cmd_addr_aligned = cmd_addr & ADDR_MASK;
    burst_end = 32'(cmd_addr_aligned[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
    crosses_4k = (burst_end > 32'd4096);
    last_beat = (beat_cnt_q == len_q);
  end

  // State and command registers; async reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      started_q  <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
    end
  end

  // Next-state and handshake outputs; started_q holds cmd_ready low until the first edge after reset
  always_comb begin
    state_d       = state_q;
    started_d     = 1'b1;
    write_d       = write_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    resp_d        = resp_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done_valid    = 1'b0;
    done_resp     = resp_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready = started_q;
        if (cmd_valid && started_q) begin
          write_d    = cmd_write;
          addr_d     = cmd_addr_aligned;
          len_d      = cmd_len;
          beat_cnt_d = '0;
          resp_d     = 2'b00;
          if (crosses_4k)     state_d = S_ERR;
          else if (cmd_write) state_d = S_AW;
          else                state_d = S_AR;
        end
      end
      S_ERR: begin
        done_valid = 1'b1;
        done_resp  = 2'b10;
        state_d    = S_IDLE;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_beat;
        if (wr_valid && m_axi_wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          resp_d  = (m_axi_bresp != 2'b00) ? 2'b10 : 2'b00;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_last      = last_beat;
        if (m_axi_rvalid && rd_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Error is sticky: any bad rresp or rlast out of step with our own count
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat)) resp_d = 2'b10;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - scoreboard bench for axi_burst_master against an AXI4 memory model
module tb_axi_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0]  cmd_len = 0;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_strb = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready = 0;
  logic        done_valid, done_write;
  logic [1:0]  done_resp;
  logic [7:0]  m_axi_awid, m_axi_arid, m_axi_awlen, m_axi_arlen;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic        m_axi_awvalid, m_axi_awready = 0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 0;
  logic [7:0]  m_axi_bid = 0, m_axi_rid = 0;
  logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
  logic        m_axi_bvalid = 0, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready = 0;
  logic [31:0] m_axi_rdata = 0;
  logic        m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [15:0] addr; logic [7:0] len;} addr_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wbeat_t;
  typedef struct packed {logic [31:0] data; logic last;} rbeat_t;
  typedef struct packed {logic write; logic [1:0] resp;} done_t;

  addr_t  exp_aw[$], exp_ar[$];
  wbeat_t wq[$], exp_w[$];
  rbeat_t exp_rd[$];
  done_t  exp_done[$];

  // Slave memory model state
  logic [31:0] mem [0:16383];
  logic        w_active = 0, b_pend = 0, keep_b = 0, keep_r = 0;
  logic [15:0] w_addr = 0, r_addr = 0;
  logic [1:0]  b_resp_val = 0;
  int          r_left = 0, r_beat = 0, aw_hold = 0, inject_r_beat = -1;
  logic        inject_bresp = 0, bad_rlast = 0, stall_en = 1;
  int          aw_hs = 0, ar_hs = 0, w_hs = 0, axi_valid_cycles = 0;
  int          rd_mode = 0;

  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

  function automatic logic rnd_ready();
    return stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Slave: evaluate handshakes at negedge (inputs are stable between posedge+1 and posedge)
  always @(negedge clk) begin : slave_sample
    addr_t  a;
    wbeat_t eb;
    if (rst) begin
      w_active = 0; b_pend = 0; r_left = 0; keep_b = 0; keep_r = 0; aw_hold = 0;
    end else begin
      if (m_axi_awvalid || m_axi_arvalid) axi_valid_cycles++;
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs++;
        check("w_after_aw", w_active, 1);
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          eb = exp_w.pop_front();
          check("w_data", m_axi_wdata, eb.data);
          check("w_strb", m_axi_wstrb, eb.strb);
          check("w_last", m_axi_wlast, eb.last);
        end
        for (int i = 0; i < 4; i++)
          if (m_axi_wstrb[i]) mem[w_addr[15:2]][8*i +: 8] = m_axi_wdata[8*i +: 8];
        w_addr = w_addr + 16'd4;
        if (m_axi_wlast) begin
          w_active = 0; b_pend = 1;
          b_resp_val = inject_bresp ? 2'b10 : 2'b00;
          inject_bresp = 0;
        end
      end
      if (m_axi_awvalid && aw_hold > 0) aw_hold--;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs++;
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          a = exp_aw.pop_front();
          check("aw_addr", m_axi_awaddr, a.addr);
          check("aw_len", m_axi_awlen, a.len);
          check("aw_size_burst", {m_axi_awsize, m_axi_awburst}, {3'd2, 2'b01});
          check("aw_attrs", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awid}, {1'b0, 4'b0011, 3'b000, 8'h00});
        end
        w_active = 1; w_addr = m_axi_awaddr;
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      keep_b = m_axi_bvalid && !m_axi_bready;
      if (m_axi_rvalid && m_axi_rready) begin
        r_left--; r_addr = r_addr + 16'd4; r_beat++;
        if (r_left == 0) begin inject_r_beat = -1; bad_rlast = 0; end
      end
      keep_r = m_axi_rvalid && !m_axi_rready;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_hs++;
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          a = exp_ar.pop_front();
          check("ar_addr", m_axi_araddr, a.addr);
          check("ar_len", m_axi_arlen, a.len);
          check("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {3'd2, 2'b01});
        end
        r_left = m_axi_arlen + 1; r_addr = m_axi_araddr; r_beat = 0;
      end
    end
  end

  // Slave: drive ready/valid/data just after the active edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
      m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_bresp = 0;
    end else begin
      m_axi_awready = (aw_hold > 0) ? 1'b0 : rnd_ready();
      m_axi_wready  = rnd_ready();
      m_axi_bvalid  = b_pend && (keep_b || rnd_ready());
      m_axi_bresp   = b_resp_val;
      m_axi_arready = rnd_ready();
      m_axi_rvalid  = (r_left > 0) && (keep_r || rnd_ready());
      m_axi_rdata   = mem[r_addr[15:2]];
      m_axi_rresp   = (r_beat == inject_r_beat) ? 2'b10 : 2'b00;
      m_axi_rlast   = (r_left == 1) || (bad_rlast && r_beat == 0);
    end
  end

  // Write-beat source and read-beat sink
  always @(posedge clk) begin
    #1;
    if (wq.size() > 0 && !rst) begin
      wr_valid = 1; wr_data = wq[0].data; wr_strb = wq[0].strb;
    end else begin
      wr_valid = 0; wr_data = 0; wr_strb = 0;
    end
    case (rd_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) if (!rst && wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());

  // Monitor: read stream and completion scoreboard
  always @(negedge clk) begin : monitor
    rbeat_t er;
    done_t  ed;
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          er = exp_rd.pop_front();
          check("rd_data", rd_data, er.data);
          check("rd_last", rd_last, er.last);
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          ed = exp_done.pop_front();
          check("done_write", done_write, ed.write);
          check("done_resp", done_resp, ed.resp);
        end
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
    check("cmd_accept_timeout", (t < 500), 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_done.size() > 0 || exp_rd.size() > 0) && t < 3000) begin @(negedge clk); t++; end
    check("completion_timeout", (t < 3000), 1);
    @(negedge clk);
  endtask

  task automatic queue_write(input logic [15:0] a, input logic [7:0] l, input logic [31:0] base,
                             input logic [3:0] strb, input logic [1:0] resp);
    wbeat_t b;
    for (int i = 0; i <= int'(l); i++) begin
      b.data = base + 32'(i); b.strb = strb; b.last = (i == int'(l));
      wq.push_back(b); exp_w.push_back(b);
    end
    exp_aw.push_back('{a, l});
    exp_done.push_back('{1'b1, resp});
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [31:0] base,
                          input logic [3:0] strb, input logic [1:0] resp);
    queue_write(a, l, base, strb, resp);
    send_cmd(1'b1, a, l);
    wait_idle();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] a_exp, input logic [7:0] l,
                         input logic [31:0] base, input logic [1:0] resp);
    rbeat_t r;
    for (int i = 0; i <= int'(l); i++) begin
      r.data = base + 32'(i); r.last = (i == int'(l));
      exp_rd.push_back(r);
    end
    exp_ar.push_back('{a_exp, l});
    exp_done.push_back('{1'b0, resp});
    send_cmd(1'b0, a, l);
    wait_idle();
  endtask

  function automatic logic [8:0] ctl_outs();
    return {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
            m_axi_rready, done_valid, rd_valid, wr_ready};
  endfunction

  initial begin : watchdog
    #800000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : stimulus
    int t, cnt0, w0;
    #2;
    check("reset_outputs", ctl_outs(), 9'h0);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    #1 check("cmd_ready_pre_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("cmd_ready_post_edge", cmd_ready, 1);

    // Single-beat write and read-back; unaligned read address is forced down to 0x0010
    do_write(16'h0010, 8'd0, 32'hDEADBEEF, 4'hF, 2'b00);
    do_read(16'h0010, 16'h0010, 8'd0, 32'hDEADBEEF, 2'b00);
    do_read(16'h0013, 16'h0010, 8'd0, 32'hDEADBEEF, 2'b00);

    // Four-beat write then read with rd_ready toggling
    do_write(16'h0100, 8'd3, 32'd1, 4'hF, 2'b00);
    rd_mode = 1;
    do_read(16'h0100, 16'h0100, 8'd3, 32'd1, 2'b00);
    rd_mode = 2;

    // Partial strobe over zeroed memory
    do_write(16'h0300, 8'd0, 32'h11223344, 4'h3, 2'b00);
    do_read(16'h0300, 16'h0300, 8'd0, 32'h00003344, 2'b00);

    // AW stalled for 5 cycles: address held, no W beat before the handshake
    aw_hold = 5;
    queue_write(16'h0400, 8'd1, 32'h50, 4'hF, 2'b00);
    send_cmd(1'b1, 16'h0400, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("aw_stall_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_wvalid}, {1'b1, 16'h0400, 8'd1, 1'b0});
    end
    wait_idle();
    do_read(16'h0400, 16'h0400, 8'd1, 32'h50, 2'b00);

    // 4 KB crossing write and read: error one cycle after accept, no AXI request
    cnt0 = axi_valid_cycles;
    exp_done.push_back('{1'b1, 2'b10});
    send_cmd(1'b1, 16'h0FF8, 8'd3);
    @(negedge clk);
    check("cross_done_pulse", {done_valid, done_resp}, {1'b1, 2'b10});
    wait_idle();
    exp_done.push_back('{1'b0, 2'b10});
    send_cmd(1'b0, 16'h0F00, 8'd255);
    wait_idle();
    check("cross_no_axi", axi_valid_cycles - cnt0, 0);

    // Burst ending exactly at the 4 KB boundary is legal
    do_write(16'h0FF0, 8'd3, 32'h70, 4'hF, 2'b00);
    do_read(16'h0FF0, 16'h0FF0, 8'd3, 32'h70, 2'b00);

    // Error responses
    inject_bresp = 1;
    do_write(16'h0500, 8'd0, 32'h99, 4'hF, 2'b10);
    inject_r_beat = 1;
    do_read(16'h0100, 16'h0100, 8'd3, 32'd1, 2'b10);
    bad_rlast = 1;
    do_read(16'h0100, 16'h0100, 8'd1, 32'd1, 2'b10);
    do_read(16'h0100, 16'h0100, 8'd1, 32'd1, 2'b00);

    // Asynchronous reset during beat 2 of a 4-beat write
    queue_write(16'h0200, 8'd3, 32'hA0, 4'hF, 2'b00);
    w0 = w_hs;
    send_cmd(1'b1, 16'h0200, 8'd3);
    t = 0;
    while (w_hs == w0 && t < 500) begin @(negedge clk); t++; end
    check("rst_test_first_beat", (t < 500), 1);
    @(posedge clk); #3;
    rst = 1;
    #1 check("async_rst_outputs", ctl_outs(), 9'h0);
    wq.delete(); exp_w.delete(); exp_aw.delete(); exp_ar.delete(); exp_rd.delete(); exp_done.delete();
    repeat (2) @(posedge clk);
    #3 rst = 0;
    #1 check("rst2_cmd_ready_pre_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("rst2_cmd_ready_post_edge", cmd_ready, 1);
    do_write(16'h0020, 8'd0, 32'hDEADBEEF, 4'hF, 2'b00);
    do_read(16'h0020, 16'h0020, 8'd0, 32'hDEADBEEF, 2'b00);

    check("queues_drained", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
